// File: rtl/regwrite_arbiter_pkg.sv
// regwrite_pkg
// Shared types for the register-file write arbiter:
//   wb_req_t       one writeback request payload (bank, destination, data)
//   req_id_t       identity of the winning requester (REQ_NONE = no grant)
//   NUM_REQ        number of writeback requesters (ALU, MEM, UART)
//   is_zero_write  true for writes to integer register $zero, which are
//                  accepted but never reach the register file
package regwrite_pkg;

   localparam int NUM_REQ = 3;

   typedef struct packed {
      logic        AorF;
      logic [4:0]  rw;
      logic [31:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      REQ_ALU  = 2'd0,
      REQ_MEM  = 2'd1,
      REQ_UART = 2'd2,
      REQ_NONE = 2'd3
   } req_id_t;

   function automatic logic is_zero_write(wb_req_t req);
      return (req.AorF == 1'b0) && (req.rw == 5'd0);
   endfunction

endpackage

// File: rtl/regwrite_arbiter_if.sv
// regwrite_arbiter_if
// Bundles the three writeback request channels, their accept strobes, the
// registered register-file write and the per-requester starvation flags.
//   master : writeback sources / operand fetch side (drives requests)
//   slave  : the arbiter (drives readies, write port, starved)
// Optional macro REGWRITE_BYPASS_EN adds the fwd_* same-cycle forwarding
// signals.
interface regwrite_arbiter_if;

   logic        alu_valid;
   logic        alu_AorF;
   logic [4:0]  alu_rw;
   logic [31:0] alu_data;
   logic        alu_ready;

   logic        mem_valid;
   logic        mem_AorF;
   logic [4:0]  mem_rw;
   logic [31:0] mem_data;
   logic        mem_ready;

   logic        uart_valid;
   logic        uart_AorF;
   logic [4:0]  uart_rw;
   logic [31:0] uart_data;
   logic        uart_ready;

   logic        RegWrite_out;
   logic        AorF_out;
   logic [4:0]  rw_out;
   logic [31:0] write_data_out;
   logic [2:0]  starved;

`ifdef REGWRITE_BYPASS_EN
   logic        fwd_valid;
   logic        fwd_AorF;
   logic [4:0]  fwd_rw;
   logic [31:0] fwd_data;
`endif

   modport master (
      output alu_valid, alu_AorF, alu_rw, alu_data,
      output mem_valid, mem_AorF, mem_rw, mem_data,
      output uart_valid, uart_AorF, uart_rw, uart_data,
      input  alu_ready, mem_ready, uart_ready,
      input  RegWrite_out, AorF_out, rw_out, write_data_out, starved
`ifdef REGWRITE_BYPASS_EN
      , input fwd_valid, fwd_AorF, fwd_rw, fwd_data
`endif
   );

   modport slave (
      input  alu_valid, alu_AorF, alu_rw, alu_data,
      input  mem_valid, mem_AorF, mem_rw, mem_data,
      input  uart_valid, uart_AorF, uart_rw, uart_data,
      output alu_ready, mem_ready, uart_ready,
      output RegWrite_out, AorF_out, rw_out, write_data_out, starved
`ifdef REGWRITE_BYPASS_EN
      , output fwd_valid, fwd_AorF, fwd_rw, fwd_data
`endif
   );

endinterface

// File: rtl/regwrite_arbiter_age_counter.sv
// regwrite_age_counter
// Counts consecutive cycles a requester has been waiting without a grant.
// Clears on grant or when the request is withdrawn, saturates at
// STARVE_LIMIT.
//   CLK, reset (sync, active-high), valid, granted -> age
module regwrite_age_counter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AGE_W        = 4
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             valid,
   input  logic             granted,
   output logic [AGE_W-1:0] age
);

   always_ff @(posedge CLK) begin
      if (reset) begin
         age <= '0;
      end else if (!valid || granted) begin
         age <= '0;
      end else if (age != AGE_W'(STARVE_LIMIT)) begin
         age <= age + 1'b1;
      end
   end

endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
// Shares the operand-fetch register-file write port between the ALU/FPU,
// memory-load and UART-receive writeback paths. Fixed priority
// ALU > MEM > UART, except that a requester denied STARVE_LIMIT cycles in a
// row is promoted ahead of the others. The accepted write is registered and
// presented one cycle later; integer $zero writes are accepted but dropped.
// Ports:
//   CLK    clock
//   reset  synchronous, active-high
//   bus    regwrite_arbiter_if.slave (requests, readies, write port, starved)
// Optional macro REGWRITE_BYPASS_EN: drives bus.fwd_* with the winner's
// payload in the acceptance cycle for same-cycle forwarding.
module regwrite_arbiter
   import regwrite_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int AGE_W        = 4
) (
   input  logic          CLK,
   input  logic          reset,
   regwrite_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0] valid_vec;
   logic [NUM_REQ-1:0] promoted;
   logic [NUM_REQ-1:0] grant_vec;
   logic [AGE_W-1:0]   age [NUM_REQ];
   wb_req_t            req [NUM_REQ];
   req_id_t            winner;
   wb_req_t            win_req;
   logic               write_en;

   logic               reg_write_q;
   logic               aorf_q;
   logic [4:0]         rw_q;
   logic [31:0]        data_q;

   always_comb begin
      valid_vec = {bus.uart_valid, bus.mem_valid, bus.alu_valid};
      req[0]    = '{AorF: bus.alu_AorF,  rw: bus.alu_rw,  data: bus.alu_data};
      req[1]    = '{AorF: bus.mem_AorF,  rw: bus.mem_rw,  data: bus.mem_data};
      req[2]    = '{AorF: bus.uart_AorF, rw: bus.uart_rw, data: bus.uart_data};
      for (int i = 0; i < NUM_REQ; i++) begin
         promoted[i] = valid_vec[i] && (age[i] == AGE_W'(STARVE_LIMIT));
      end
   end

   // Promoted (starving) requesters pre-empt normal priority; within either
   // group the lowest index wins. Nothing wins while reset is held.
   always_comb begin
      winner = REQ_NONE;
      if (!reset) begin
         if (promoted[0])       winner = REQ_ALU;
         else if (promoted[1])  winner = REQ_MEM;
         else if (promoted[2])  winner = REQ_UART;
         else if (valid_vec[0]) winner = REQ_ALU;
         else if (valid_vec[1]) winner = REQ_MEM;
         else if (valid_vec[2]) winner = REQ_UART;
      end
   end

   always_comb begin
      grant_vec = '0;
      win_req   = '0;
      case (winner)
         REQ_ALU:  begin grant_vec[0] = 1'b1; win_req = req[0]; end
         REQ_MEM:  begin grant_vec[1] = 1'b1; win_req = req[1]; end
         REQ_UART: begin grant_vec[2] = 1'b1; win_req = req[2]; end
         default:  begin grant_vec = '0; win_req = '0; end
      endcase
      write_en = (winner != REQ_NONE) && !is_zero_write(win_req);
   end

   assign bus.alu_ready  = grant_vec[0];
   assign bus.mem_ready  = grant_vec[1];
   assign bus.uart_ready = grant_vec[2];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
      regwrite_age_counter #(
         .STARVE_LIMIT (STARVE_LIMIT),
         .AGE_W        (AGE_W)
      ) u_age (
         .CLK     (CLK),
         .reset   (reset),
         .valid   (valid_vec[g]),
         .granted (grant_vec[g]),
         .age     (age[g])
      );
      assign bus.starved[g] = (age[g] == AGE_W'(STARVE_LIMIT));
   end

   // Payload only loads on a real write so that the bank/destination/data
   // hold their previous value while RegWrite_out is low, including after a
   // discarded $zero write.
   always_ff @(posedge CLK) begin
      if (reset) begin
         reg_write_q <= 1'b0;
         aorf_q      <= 1'b0;
         rw_q        <= '0;
         data_q      <= '0;
      end else begin
         reg_write_q <= write_en;
         if (write_en) begin
            aorf_q <= win_req.AorF;
            rw_q   <= win_req.rw;
            data_q <= win_req.data;
         end
      end
   end

   assign bus.RegWrite_out   = reg_write_q;
   assign bus.AorF_out       = aorf_q;
   assign bus.rw_out         = rw_q;
   assign bus.write_data_out = data_q;

`ifdef REGWRITE_BYPASS_EN
   assign bus.fwd_valid = write_en;
   assign bus.fwd_AorF  = win_req.AorF;
   assign bus.fwd_rw    = win_req.rw;
   assign bus.fwd_data  = win_req.data;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter
// Directed scenarios with literal expectations followed by randomized
// traffic. A reference model (per-requester wait counts, priority rule,
// expected register-file write) is advanced once per clock and compared
// against the arbiter on every falling edge.
// Honors REGWRITE_BYPASS_EN to also check the fwd_* outputs.
module tb_regwrite_arbiter;

   localparam int LIMIT = 4;

   logic CLK;
   logic reset;

   regwrite_arbiter_if bus ();

   regwrite_arbiter #(
      .STARVE_LIMIT (LIMIT),
      .AGE_W        (4)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   // Requester stimulus, index 0 = ALU, 1 = MEM, 2 = UART
   logic        reqValid [3];
   logic        reqAorF  [3];
   logic [4:0]  reqRw    [3];
   logic [31:0] reqData  [3];

   assign bus.alu_valid  = reqValid[0];
   assign bus.alu_AorF   = reqAorF[0];
   assign bus.alu_rw     = reqRw[0];
   assign bus.alu_data   = reqData[0];
   assign bus.mem_valid  = reqValid[1];
   assign bus.mem_AorF   = reqAorF[1];
   assign bus.mem_rw     = reqRw[1];
   assign bus.mem_data   = reqData[1];
   assign bus.uart_valid = reqValid[2];
   assign bus.uart_AorF  = reqAorF[2];
   assign bus.uart_rw    = reqRw[2];
   assign bus.uart_data  = reqData[2];

   // Reference model state
   int          ageM [3];
   logic        expWe;
   logic        expAorF;
   logic [4:0]  expRw;
   logic [31:0] expData;
   int          lastWinner;
   bit          modelOn;

   int checks;
   int failures;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner by the arbitration rules: starving requesters first, then
   // plain priority, lowest index first in both cases.
   function automatic int modelWinner();
      for (int i = 0; i < 3; i++) if (reqValid[i] && ageM[i] == LIMIT) return i;
      for (int i = 0; i < 3; i++) if (reqValid[i]) return i;
      return 3;
   endfunction

   function automatic logic isZero(input int i);
      return (reqAorF[i] == 1'b0) && (reqRw[i] == 5'd0);
   endfunction

   function automatic logic [2:0] actGrant();
      return {bus.uart_valid & bus.uart_ready, bus.mem_valid & bus.mem_ready,
              bus.alu_valid & bus.alu_ready};
   endfunction

   // Advance one clock and the model with the inputs that were present at
   // that edge; inputs may be changed by the caller afterwards.
   task automatic stepCycle();
      int w;
      @(posedge CLK);
      #1;
      w = reset ? 3 : modelWinner();
      if (reset) begin
         for (int i = 0; i < 3; i++) ageM[i] = 0;
         expWe = 0; expAorF = 0; expRw = '0; expData = '0;
      end else begin
         expWe = 0;
         if (w < 3 && !isZero(w)) begin
            expWe   = 1;
            expAorF = reqAorF[w];
            expRw   = reqRw[w];
            expData = reqData[w];
         end
         for (int i = 0; i < 3; i++) begin
            if (!reqValid[i] || w == i) ageM[i] = 0;
            else if (ageM[i] < LIMIT) ageM[i] = ageM[i] + 1;
         end
      end
      lastWinner = w;
      modelOn = 1;
   endtask

   task automatic applyStimulus(input int i, input logic v, input logic aorf,
                                input logic [4:0] rw, input logic [31:0] data);
      reqValid[i] = v;
      reqAorF[i]  = aorf;
      reqRw[i]    = rw;
      reqData[i]  = data;
   endtask

   // Per-cycle comparison against the model
   int         cmpW;
   logic [2:0] cmpExpG;
   logic [2:0] cmpExpS;
   always @(negedge CLK) begin
      if (modelOn) begin
         cmpW    = reset ? 3 : modelWinner();
         cmpExpG = (cmpW < 3) ? 3'(1 << cmpW) : 3'b000;
         checkOutput("grant", 64'(actGrant()), 64'(cmpExpG));
         if (reset)
            checkOutput("ready_in_reset",
                        64'({bus.uart_ready, bus.mem_ready, bus.alu_ready}), 64'd0);
         for (int i = 0; i < 3; i++) cmpExpS[i] = (ageM[i] == LIMIT);
         checkOutput("starved", 64'(bus.starved), 64'(cmpExpS));
         checkOutput("RegWrite_out", 64'(bus.RegWrite_out), 64'(expWe));
         checkOutput("AorF_out", 64'(bus.AorF_out), 64'(expAorF));
         checkOutput("rw_out", 64'(bus.rw_out), 64'(expRw));
         checkOutput("write_data_out", 64'(bus.write_data_out), 64'(expData));
`ifdef REGWRITE_BYPASS_EN
         checkOutput("fwd_valid", 64'(bus.fwd_valid),
                     64'((cmpW < 3) && !isZero(cmpW)));
         if (cmpW < 3 && !isZero(cmpW)) begin
            checkOutput("fwd_AorF", 64'(bus.fwd_AorF), 64'(reqAorF[cmpW]));
            checkOutput("fwd_rw", 64'(bus.fwd_rw), 64'(reqRw[cmpW]));
            checkOutput("fwd_data", 64'(bus.fwd_data), 64'(reqData[cmpW]));
         end
`endif
      end
   end

   initial begin
      checks = 0; failures = 0; modelOn = 0; lastWinner = 3;
      for (int i = 0; i < 3; i++) ageM[i] = 0;
      expWe = 0; expAorF = 0; expRw = '0; expData = '0;
      reset = 1'b1;
      applyStimulus(0, 1'b1, 1'b0, 5'd5, 32'h11);
      applyStimulus(1, 1'b1, 1'b0, 5'd6, 32'h22);
      applyStimulus(2, 1'b1, 1'b0, 5'd7, 32'h33);

      // Reset with every requester asserting valid
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         @(negedge CLK);
         checkOutput("rst_readies", 64'({bus.uart_ready, bus.mem_ready, bus.alu_ready}), 64'd0);
         checkOutput("rst_we", 64'(bus.RegWrite_out), 64'd0);
         checkOutput("rst_rw", 64'(bus.rw_out), 64'd0);
         checkOutput("rst_data", 64'(bus.write_data_out), 64'd0);
         checkOutput("rst_starved", 64'(bus.starved), 64'd0);
      end

      // Fixed priority order ALU, MEM, UART
      stepCycle(); reset = 1'b0;
      @(negedge CLK);
      checkOutput("prio_alu", 64'(actGrant()), 64'h1);
      stepCycle(); reqValid[0] = 1'b0;
      @(negedge CLK);
      checkOutput("prio_mem", 64'(actGrant()), 64'h2);
      checkOutput("prio_out5", {31'd0, bus.RegWrite_out, bus.rw_out, bus.write_data_out}, {31'd0, 1'b1, 5'd5, 32'h11});
      stepCycle(); reqValid[1] = 1'b0;
      @(negedge CLK);
      checkOutput("prio_uart", 64'(actGrant()), 64'h4);
      checkOutput("prio_out6", {31'd0, bus.RegWrite_out, bus.rw_out, bus.write_data_out}, {31'd0, 1'b1, 5'd6, 32'h22});
      stepCycle(); reqValid[2] = 1'b0;
      @(negedge CLK);
      checkOutput("prio_out7", {31'd0, bus.RegWrite_out, bus.rw_out, bus.write_data_out}, {31'd0, 1'b1, 5'd7, 32'h33});

      // UART starved by continuous ALU traffic
      stepCycle();
      applyStimulus(0, 1'b1, 1'b0, 5'd1, 32'h100);
      applyStimulus(2, 1'b1, 1'b0, 5'd9, 32'hAB);
      for (int k = 0; k < LIMIT; k++) begin
         @(negedge CLK);
         checkOutput("starve_denied", 64'(actGrant()), 64'h1);
         stepCycle();
         reqData[0] = 32'h101 + 32'(k);
      end
      @(negedge CLK);
      checkOutput("starve_flag", 64'(bus.starved), 64'h4);
      checkOutput("starve_grant", 64'(actGrant()), 64'h4);
      stepCycle(); reqValid[0] = 1'b0; reqValid[2] = 1'b0;
      @(negedge CLK);
      checkOutput("starve_out", {31'd0, bus.RegWrite_out, bus.rw_out, bus.write_data_out}, {31'd0, 1'b1, 5'd9, 32'hAB});
      checkOutput("starve_clear", 64'(bus.starved), 64'h0);

      // Integer $zero dropped, float r0 written
      stepCycle();
      applyStimulus(1, 1'b1, 1'b0, 5'd0, 32'hFFFF);
      @(negedge CLK);
      checkOutput("zero_ready", 64'(bus.mem_ready), 64'h1);
      stepCycle();
      applyStimulus(1, 1'b1, 1'b1, 5'd0, 32'hFFFF);
      @(negedge CLK);
      checkOutput("zero_dropped", 64'(bus.RegWrite_out), 64'h0);
      stepCycle(); reqValid[1] = 1'b0;
      @(negedge CLK);
      checkOutput("f0_write", {bus.RegWrite_out, bus.AorF_out, bus.rw_out}, {1'b1, 1'b1, 5'd0});

      // Reset right after an accepted write
      stepCycle();
      applyStimulus(0, 1'b1, 1'b0, 5'd3, 32'h3333);
      @(negedge CLK);
      checkOutput("midrst_grant", 64'(actGrant()), 64'h1);
      stepCycle(); reqValid[0] = 1'b0; reset = 1'b1;
      @(negedge CLK);
      checkOutput("midrst_pending", {bus.RegWrite_out, bus.rw_out}, {1'b1, 5'd3});
      stepCycle(); reset = 1'b0;
      @(negedge CLK);
      checkOutput("midrst_dropped", {bus.RegWrite_out, bus.rw_out, bus.write_data_out}, 38'd0);

      // Forwarded payload precedes the registered write
      stepCycle();
      applyStimulus(0, 1'b1, 1'b0, 5'd12, 32'hDEAD);
      @(negedge CLK);
`ifdef REGWRITE_BYPASS_EN
      checkOutput("fwd_direct", {bus.fwd_valid, bus.fwd_rw, bus.fwd_data}, {1'b1, 5'd12, 32'hDEAD});
`endif
      stepCycle(); reqValid[0] = 1'b0;
      @(negedge CLK);
      checkOutput("fwd_out", {bus.RegWrite_out, bus.rw_out, bus.write_data_out}, {1'b1, 5'd12, 32'hDEAD});

      // Randomized traffic; requests hold until accepted
      for (int n = 0; n < 3000; n++) begin
         stepCycle();
         reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 3; i++) begin
            if (!reqValid[i] || lastWinner == i) begin
               reqValid[i] = ($urandom_range(0, 3) != 0);
               reqAorF[i]  = 1'($urandom);
               reqRw[i]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
               reqData[i]  = $urandom;
            end
         end
      end
      stepCycle();
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
